// File: rtl/ps2_key_event_sequencer_if.sv
// Bus bundle for ps2_key_event_sequencer: scan-code input, event FIFO output,
// held-key vector, FIFO level and sticky error flags.
interface ps2_key_event_sequencer_if #(
  parameter int FIFO_DEPTH = 4
) ();
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]    byte_in;
  logic          byte_valid;
  // Handshake: event_valid is high while the FIFO holds an entry and event_* show
  // that head entry; an event transfers in any cycle with event_valid && event_ready.
  logic [7:0]    event_code;
  logic          event_ext;
  logic          event_break;
  logic          event_valid;
  logic          event_ready;
  logic [4:0]    key_state;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          proto_err;
  logic          err_clr;

  modport master (
    input  byte_in, byte_valid, event_ready, err_clr,
    output event_code, event_ext, event_break, event_valid,
           key_state, fifo_level, overflow, proto_err
  );

  modport slave (
    output byte_in, byte_valid, event_ready, err_clr,
    input  event_code, event_ext, event_break, event_valid,
           key_state, fifo_level, overflow, proto_err
  );
endinterface

// File: rtl/ps2_key_event_sequencer.sv
// PS/2 scan-code prefix tracker (E0/F0) feeding a first-word fall-through event FIFO.
// Optional prefix timeout is enabled by defining PS2_SEQ_TIMEOUT_EN.
module ps2_key_event_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ps2_key_event_sequencer_if.master  bus,
  output logic [1:0]                 o_dbg_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ps2_key_event_sequencer: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } event_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_is_e0;
  logic          w_is_f0;
  logic          w_is_bad;
  logic          w_final;
  logic          w_tmo_hit;
  event_t        w_event;

  event_t        r_mem [FIFO_DEPTH];
  event_t        r_last;
  event_t        w_head;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  logic [4:0]    r_key;
  logic [4:0]    w_key_hit;
  logic          r_ovf;
  logic          r_perr;

  assign w_is_e0  = (bus.byte_in == 8'hE0);
  assign w_is_f0  = (bus.byte_in == 8'hF0);
  assign w_is_bad = (bus.byte_in == 8'h00) || (bus.byte_in == 8'hFF);
  assign w_final  = bus.byte_valid && !w_is_e0 && !w_is_f0 && !w_is_bad;

  assign w_event.ext  = (r_state == S_EXT) || (r_state == S_EXT_BRK);
  assign w_event.brk  = (r_state == S_BRK) || (r_state == S_EXT_BRK);
  assign w_event.code = bus.byte_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.byte_valid) begin
      if (w_is_e0) begin
        w_state_nxt = S_EXT;
      end else if (w_is_f0) begin
        case (r_state)
          S_IDLE:  w_state_nxt = S_BRK;
          S_EXT:   w_state_nxt = S_EXT_BRK;
          default: w_state_nxt = r_state;
        endcase
      end else begin
        w_state_nxt = S_IDLE;
      end
    end else if (w_tmo_hit) begin
      w_state_nxt = S_IDLE;
    end
  end

`ifdef PS2_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_tmo_cnt;

  assign w_tmo_hit = (r_state != S_IDLE) && !bus.byte_valid &&
                     (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_tmo_cnt <= '0;
    else if (r_state == S_IDLE || bus.byte_valid || w_tmo_hit)
      r_tmo_cnt <= '0;
    else
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_pop   = !w_empty && bus.event_ready;
  assign w_push  = w_final && (!w_full || w_pop);
  assign w_drop  = w_final && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_event;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Once drained, the outputs keep showing the most recently consumed event.
  assign w_head = w_empty ? r_last : r_mem[r_rd_ptr];

  always_comb begin
    w_key_hit = '0;
    if (w_final) begin
      case ({w_event.ext, bus.byte_in})
        9'h175:  w_key_hit = 5'b00001;
        9'h172:  w_key_hit = 5'b00010;
        9'h16B:  w_key_hit = 5'b00100;
        9'h174:  w_key_hit = 5'b01000;
        9'h029:  w_key_hit = 5'b10000;
        default: w_key_hit = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key  <= '0;
      r_ovf  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_key <= w_event.brk ? (r_key & ~w_key_hit) : (r_key | w_key_hit);
      if (w_drop)           r_ovf <= 1'b1;
      else if (bus.err_clr) r_ovf <= 1'b0;
      if (bus.byte_valid && w_is_bad) r_perr <= 1'b1;
      else if (bus.err_clr)           r_perr <= 1'b0;
    end
  end

  assign bus.event_code  = w_head.code;
  assign bus.event_ext   = w_head.ext;
  assign bus.event_break = w_head.brk;
  assign bus.event_valid = !w_empty;
  assign bus.key_state   = r_key;
  assign bus.fifo_level  = r_level;
  assign bus.overflow    = r_ovf;
  assign bus.proto_err   = r_perr;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_ps2_key_event_sequencer.sv
// Scoreboard bench for ps2_key_event_sequencer: directed test-plan sequences plus
// randomized byte streams checked against a prefix/queue reference model.
module tb_ps2_key_event_sequencer;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  ps2_key_event_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_key_event_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Expected events, packed as {ext, brk, code}.
  logic [9:0] exp_q[$];
  logic [9:0] last_ev;
  int         m_cnt;
  bit         m_ext, m_brk, m_ovf, m_perr;
  logic [4:0] m_key;
  int         m_tmo;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] key_bit(input bit ext, input logic [7:0] code);
    if (ext && code == 8'h75) return 5'b00001;
    if (ext && code == 8'h72) return 5'b00010;
    if (ext && code == 8'h6B) return 5'b00100;
    if (ext && code == 8'h74) return 5'b01000;
    if (!ext && code == 8'h29) return 5'b10000;
    return 5'b00000;
  endfunction

  // Reference model: prefix flags, bounded queue occupancy, held keys, sticky flags.
  always @(posedge clk) begin : model
    bit         pop;
    logic [9:0] ev;
    logic [4:0] hit;
    if (!rst_n) begin
      m_cnt = 0; m_ext = 0; m_brk = 0; m_ovf = 0; m_perr = 0; m_key = '0; m_tmo = 0;
    end else begin
      pop = (m_cnt > 0) && bus.event_ready;
      if (bus.err_clr) begin m_ovf = 0; m_perr = 0; end
      if (bus.byte_valid) begin
        m_tmo = 0;
        case (bus.byte_in)
          8'hE0: begin m_ext = 1; m_brk = 0; end
          8'hF0: m_brk = 1;
          8'h00, 8'hFF: begin m_perr = 1; m_ext = 0; m_brk = 0; end
          default: begin
            ev  = {m_ext, m_brk, bus.byte_in};
            hit = key_bit(m_ext, bus.byte_in);
            m_key = m_brk ? (m_key & ~hit) : (m_key | hit);
            if (m_cnt < DEPTH || pop) begin
              exp_q.push_back(ev);
              m_cnt++;
            end else begin
              m_ovf = 1;
            end
            m_ext = 0; m_brk = 0;
          end
        endcase
      end
`ifdef PS2_SEQ_TIMEOUT_EN
      else if (m_ext || m_brk) begin
        if (m_tmo == TMO - 1) begin m_ext = 0; m_brk = 0; m_tmo = 0; end
        else m_tmo++;
      end
`endif
      if (pop) m_cnt--;
    end
  end

  always @(negedge clk) begin : monitor
    logic [9:0] exp;
    if (!rst_n) begin
      exp_q.delete();
      last_ev = '0;
    end else begin
      chk("event_valid", 32'(bus.event_valid), 32'(m_cnt != 0));
      chk("fifo_level", 32'(bus.fifo_level), 32'(m_cnt));
      chk("key_state", 32'(bus.key_state), 32'(m_key));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("proto_err", 32'(bus.proto_err), 32'(m_perr));
      if (bus.event_valid) begin
        if (bus.event_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_event: got %0h expected none (t=%0t)",
                     {bus.event_ext, bus.event_break, bus.event_code}, $time);
          end else begin
            exp = exp_q.pop_front();
            chk("event", 32'({bus.event_ext, bus.event_break, bus.event_code}), 32'(exp));
            last_ev = exp;
          end
        end
      end else begin
        chk("hold_last", 32'({bus.event_ext, bus.event_break, bus.event_code}), 32'(last_ev));
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] b, input logic rdy, input logic clr);
    bus.byte_valid  = v;
    bus.byte_in     = b;
    bus.event_ready = rdy;
    bus.err_clr     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic rdy);
    drive(1'b1, b, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.event_valid), 0);
    chk({tag, "_code"}, 32'(bus.event_code), 0);
    chk({tag, "_ext"}, 32'(bus.event_ext), 0);
    chk({tag, "_break"}, 32'(bus.event_break), 0);
    chk({tag, "_key"}, 32'(bus.key_state), 0);
    chk({tag, "_level"}, 32'(bus.fifo_level), 0);
    chk({tag, "_ovf"}, 32'(bus.overflow), 0);
    chk({tag, "_perr"}, 32'(bus.proto_err), 0);
    chk({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 11))
      0:       return 8'hE0;
      1:       return 8'hF0;
      2:       return 8'h00;
      3:       return 8'hFF;
      4:       return 8'h75;
      5:       return 8'h72;
      6:       return 8'h6B;
      7:       return 8'h74;
      8:       return 8'h29;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin : stim
    int rdy_pct;
    bus.byte_valid = 1'b0; bus.byte_in = 8'h00; bus.event_ready = 1'b0; bus.err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Extended make, then extended break, then space make/break.
    send(8'hE0, 1'b1); send(8'h75, 1'b1);
    chk("tp_up_make_key", 32'(bus.key_state), 32'h01);
    idle(2, 1'b1);
    chk("tp_level_zero", 32'(bus.fifo_level), 0);
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h75, 1'b1);
    chk("tp_up_break_key", 32'(bus.key_state), 32'h00);
    send(8'h29, 1'b1);
    chk("tp_space_make", 32'(bus.key_state), 32'h10);
    send(8'hF0, 1'b1); send(8'h29, 1'b1);
    chk("tp_space_break", 32'(bus.key_state), 32'h00);
    idle(3, 1'b1);

    // Overflow with consumer stalled, clear, then full push with simultaneous pop.
    send(8'h1C, 1'b0); send(8'h1B, 1'b0); send(8'h23, 1'b0); send(8'h2B, 1'b0); send(8'h34, 1'b0);
    chk("tp_full_level", 32'(bus.fifo_level), 4);
    chk("tp_overflow_set", 32'(bus.overflow), 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("tp_overflow_clr", 32'(bus.overflow), 0);
    send(8'h1D, 1'b1);
    chk("tp_push_pop_level", 32'(bus.fifo_level), 4);
    chk("tp_push_pop_ovf", 32'(bus.overflow), 0);
    idle(6, 1'b1);
    chk("tp_drained", 32'(bus.fifo_level), 0);

    // Protocol error drops the prefix; F0 then E0 restarts as extended make.
    send(8'hE0, 1'b1); send(8'hFF, 1'b1); send(8'h75, 1'b1);
    chk("tp_proto_err", 32'(bus.proto_err), 1);
    chk("tp_keypad8_nokey", 32'(bus.key_state), 0);
    send(8'hF0, 1'b1); send(8'hE0, 1'b1); send(8'h6B, 1'b1);
    chk("tp_left_make", 32'(bus.key_state), 32'h04);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    chk("tp_proto_clr", 32'(bus.proto_err), 0);

`ifdef PS2_SEQ_TIMEOUT_EN
    send(8'hF0, 1'b1);
    idle(20, 1'b1);
    chk("tp_timeout_idle", 32'(dbg_state), 0);
    send(8'h1C, 1'b1);
    idle(2, 1'b1);
`endif

    // Randomized byte stream with varying consumer throughput.
    rdy_pct = 50;
    for (int i = 0; i < 2500; i++) begin
      if (i % 64 == 0) rdy_pct = $urandom_range(0, 100);
      drive(1'($urandom_range(0, 1)), rand_byte(),
            1'($urandom_range(1, 100) <= rdy_pct), 1'($urandom_range(0, 40) == 0));
    end

    // Reset between E0 and 75 discards everything.
    send(8'hE0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    idle(2, 1'b0);
    rst_n = 1'b1;
    idle(3, 1'b1);
    chk("midrst_no_event", 32'(bus.fifo_level), 0);

    idle(10, 1'b1);
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
